fetch_stage: RTL
================

# fetch_stage

IF stage of the 5-stage MIPS pipeline: owns the PC, drives a ready-handshaked instruction-memory port, and produces the IF/ID pipeline register consumed by the ID stage. It supplies ID with the instruction, PC+4 and the rs/rt/immediate fields for the register file and sign-extender. It also accepts the hazard unit's stall and the ID-stage branch redirect, and keeps a retired-fetch counter.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low; 0 = reset asserted
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address (= PC)
- imem_ready  input  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  input  32  instruction word, valid when imem_req & imem_ready
- stall_if  input  1  hazard unit: hold PC and IF/ID
- branch_taken  input  1  ID resolved a taken branch/jump; redirect fetch
- branch_target  input  32  redirect PC (word aligned)
- if_id_instr  output  32  IF/ID instruction (0 = NOP when bubble)
- if_id_pc_plus4  output  32  IF/ID PC+4
- if_id_valid  output  1  IF/ID holds a real instruction
- rs_addr  output  5  if_id_instr[25:21], combinational
- rt_addr  output  5  if_id_instr[20:16], combinational
- imm16  output  16  if_id_instr[15:0], combinational
- fetch_count  output  32  number of instructions loaded valid into IF/ID

## Operation
- States: S_REQ (request outstanding), S_HELD (instruction received during stall, buffered in skid register).
- imem_req = (state==S_REQ) & reset; imem_addr = pc.
- Event priority each posedge: branch_taken & !stall_if > stall_if > normal. branch_taken while stall_if=1 is ignored; the hazard unit only presents a branch when stall_if=0.
- Redirect (branch_taken & !stall_if, any state): pc<=branch_target; IF/ID <= bubble (instr 0, valid 0, pc_plus4 unchanged); skid buffer and any accepted imem_rdata this cycle discarded; state<=S_REQ; fetch_count unchanged.
- S_REQ, imem_ready=1, stall_if=0: IF/ID <= {imem_rdata, pc+4, valid 1}; pc<=pc+4; fetch_count+1; stay S_REQ.
- S_REQ, imem_ready=1, stall_if=1: skid <= {imem_rdata, pc+4}; IF/ID held; pc held; state<=S_HELD.
- S_REQ, imem_ready=0, stall_if=0: IF/ID <= bubble; pc held (imem_addr stable).
- S_REQ, imem_ready=0, stall_if=1: IF/ID and pc held.
- S_HELD, stall_if=1: everything held; imem_req=0.
- S_HELD, stall_if=0: IF/ID <= {skid, valid 1}; pc<=pc+4; fetch_count+1; state<=S_REQ. Buffered address never refetched.
- pc, pc+4 arithmetic mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal, no flag. fetch_count wraps at 2^32.
- imem_addr may change while imem_req=1 & imem_ready=0 only on redirect; memory tolerates abandoned requests.

## Timing
- Reset (asynchronous, immediate, no clock needed): pc=RESET_PC, state=S_REQ, skid=0, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0; hence imem_req=0, imem_addr=RESET_PC, rs_addr=rt_addr=0, imm16=0.
- First request in the cycle after reset deasserts; reset release treated synchronously by downstream logic.
- Latency: instruction accepted at posedge N appears on if_id_instr after posedge N (visible cycle N+1). With imem_ready tied 1 and no stall: 1 instruction/cycle.
- Redirect: branch_target on imem_addr the cycle after branch_taken is sampled; one bubble in IF/ID.
- Stall release from S_HELD: IF/ID updates at the first posedge with stall_if=0; next request issues in the following cycle.
- Reset mid-S_HELD or mid-request: buffered/outstanding fetch discarded.

## Test plan
- Reset release, imem_ready=1, imem_rdata=addr|32'hA000_0000: imem_addr 0,4,8; after 3 posedges if_id_pc_plus4=0xC, if_id_instr=0xA000_0008, fetch_count=3.
- imem_ready=0 for 2 cycles at addr 0x8: imem_addr held 0x8, if_id_valid=0 and if_id_instr=0 for 2 cycles, fetch_count unchanged, then 0x8 instruction loads.
- stall_if=1 for 3 cycles while 0x10 accepted: imem_req=0 during S_HELD, IF/ID holds 0xC entry; on release if_id_pc_plus4=0x14, imem_addr next =0x14, 0x10 issued exactly once.
- branch_taken=1, branch_target=0x40 while 0xC accepted: next cycle if_id_valid=0, imem_addr=0x40, 0xC instruction never in IF/ID, fetch_count unchanged.
- branch_taken with stall_if=1 in S_HELD: ignored; then stall_if=0 with branch_taken=1: skid discarded, imem_addr=0x40.
- reset driven 0 mid-stall between clock edges: all outputs at reset values before next posedge; RESET_PC=0xBFC0_0000 parameter override gives first imem_addr 0xBFC0_0000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// IF-stage bus bundle: instruction-memory port, hazard/redirect inputs, IF/ID outputs.
// Latency: none; this is a passive grouping of wires.
// Backpressure: imem_ready from memory; stall_if from the hazard unit.
interface fetch_stage_if;
  // instruction memory port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  // hazard unit and ID-stage redirect
  logic        stall_if;
  logic        branch_taken;
  logic [31:0] branch_target;
  // IF/ID pipeline register and decoded fields
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [15:0] imm16;
  logic [31:0] fetch_count;

  // the fetch stage drives the memory request and the IF/ID register
  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    input  stall_if, branch_taken, branch_target,
    output if_id_instr, if_id_pc_plus4, if_id_valid,
    output rs_addr, rt_addr, imm16, fetch_count
  );

  // memory, hazard unit and ID stage see the mirror image
  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    output stall_if, branch_taken, branch_target,
    input  if_id_instr, if_id_pc_plus4, if_id_valid,
    input  rs_addr, rt_addr, imm16, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, issues ready-handshaked fetches, loads the IF/ID register.
// Latency: word accepted at posedge N is visible in IF/ID from cycle N+1; 1 instr/cycle.
// Backpressure: stall_if parks an accepted word in a skid register; imem_ready=0 inserts bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  // S_REQ: a request is outstanding at pc. S_HELD: the word for pc was taken
  // during a stall and sits in the skid register; no request is issued.
  typedef enum logic {
    S_REQ  = 1'b0,
    S_HELD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        redirect;
  logic [31:0] pc_plus4;

  // A branch presented together with a stall is not a real redirect.
  assign redirect = bus.branch_taken & ~bus.stall_if;
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state: redirect wins over everything, then per-state fetch handling.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Squash: wrong-path word (accepted now or buffered) is dropped,
      // pc_plus4 is left alone since a bubble carries no meaningful PC.
      pc_d          = bus.branch_target;
      if_id_instr_d = 32'h0;
      if_id_valid_d = 1'b0;
      skid_instr_d  = 32'h0;
      skid_pc4_d    = 32'h0;
      state_d       = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.imem_ready) begin
            if (!bus.stall_if) begin
              if_id_instr_d = bus.imem_rdata;
              if_id_pc4_d   = pc_plus4;
              if_id_valid_d = 1'b1;
              pc_d          = pc_plus4;
              fetch_count_d = fetch_count_q + 32'd1;
            end else begin
              // Memory already answered; keep the word instead of refetching.
              skid_instr_d = bus.imem_rdata;
              skid_pc4_d   = pc_plus4;
              state_d      = S_HELD;
            end
          end else if (!bus.stall_if) begin
            if_id_instr_d = 32'h0;
            if_id_valid_d = 1'b0;
          end
        end
        S_HELD: begin
          if (!bus.stall_if) begin
            if_id_instr_d = skid_instr_q;
            if_id_pc4_d   = skid_pc4_q;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
            state_d       = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State register with immediate asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      skid_instr_q  <= 32'h0;
      skid_pc4_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc4_q    <= skid_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Request is gated by reset so nothing is issued while reset is held.
  assign bus.imem_req       = (state_q == S_REQ) & reset;
  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = if_id_instr_q;
  assign bus.if_id_pc_plus4 = if_id_pc4_q;
  assign bus.if_id_valid    = if_id_valid_q;
  assign bus.fetch_count    = fetch_count_q;

  // Register-file and sign-extender fields come straight off IF/ID.
  assign bus.rs_addr = if_id_instr_q[25:21];
  assign bus.rt_addr = if_id_instr_q[20:16];
  assign bus.imm16   = if_id_instr_q[15:0];

endmodule
